// File: rtl/retire_trace_buffer.sv
// Retirement trace buffer: snapshots the debug register bus on each
// instruction retirement into a circular buffer drained via valid/ready.
module retire_trace_buffer #(
  parameter int NREGS  = 6,
  parameter int REG_W  = 16,
  parameter int DEPTH  = 16,
  parameter int SEQ_W  = 16,
  parameter int DROP_W = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NREGS*REG_W-1:0]         dbg_regs,
  input  logic                           dbg_instruction_retired,
  input  logic                           dbg_halted,
  input  logic                           arm,
  input  logic                           ring_mode,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic [SEQ_W+NREGS*REG_W:0]     rd_data,
  output logic [$clog2(DEPTH):0]         count,
  output logic [DROP_W-1:0]              dropped,
  output logic [1:0]                     state
);

  localparam int ENTRY_W = SEQ_W + 1 + NREGS * REG_W;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FROZEN  = 2'd2
  } state_t;

  state_t              state_q, state_next;
  logic                retired_p1;
  logic                ring_q;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count_q;
  logic [SEQ_W-1:0]    seq_q;
  logic [DROP_W-1:0]   dropped_q;
  logic [ENTRY_W-1:0]  mem [DEPTH];

  logic evt, cap, pop, full, do_write, overwrite, drop, adv_rd;

  // Saturating increment for the dropped-entry counter.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  // Event qualification and buffer occupancy decisions for this cycle.
  always_comb begin
    evt       = dbg_instruction_retired & ~retired_p1;
    cap       = (state_q == ST_CAPTURE) && evt && !arm;
    pop       = rd_valid && rd_ready && !arm;
    full      = (count_q == FULL_CNT);
    do_write  = cap && (!full || pop || ring_q);
    overwrite = cap && full && !pop && ring_q;
    drop      = cap && full && !pop;
    adv_rd    = pop || overwrite;
  end

  // Next-state logic: arm always restarts capture; a halted capture freezes.
  always_comb begin
    state_next = state_q;
    if (arm) begin
      state_next = ST_CAPTURE;
    end else if (cap && dbg_halted) begin
      state_next = ST_FROZEN;
    end
  end

  // State register and retirement edge-detect register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      retired_p1 <= 1'b0;
    end else begin
      state_q    <= state_next;
      retired_p1 <= dbg_instruction_retired;
    end
  end

  // Pointers, occupancy, sequence and drop accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      ring_q    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      seq_q     <= '0;
      dropped_q <= '0;
    end else if (arm) begin
      ring_q    <= ring_mode;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      seq_q     <= '0;
      dropped_q <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
      if (adv_rd)   rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_write && !adv_rd) begin
        count_q <= count_q + CNT_W'(1);
      end else if (adv_rd && !do_write) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (cap)  seq_q     <= seq_q + SEQ_W'(1);
      if (drop) dropped_q <= sat_inc(dropped_q);
    end
  end

  // Snapshot storage; contents are not cleared, only made unreachable.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= {seq_q, dbg_halted, dbg_regs};
    end
  end

  assign rd_valid = (count_q != '0);
  assign rd_data  = mem[rd_ptr];
  assign count    = count_q;
  assign dropped  = dropped_q;
  assign state    = state_q;

endmodule

// File: doc/retire_trace_buffer.md
Name: retire_trace_buffer

Overview:
- Synthesisable successor to the simulation-only register dump: captures a snapshot of the CPU debug registers on every instruction retirement into an on-chip circular buffer.
- Snapshots are drained later through a valid/ready port, e.g. by a UART dumper or a bench.
- Sits beside `main` and taps the dbg_* buses.
- Generalised over register count, register width, depth and sequence width; adds runtime fill/ring mode, stop-on-halt freeze and drop accounting.

Parameters:
- NREGS, 6, number of debug registers per snapshot (PC, SP, AF, BC, DE, HL order, index 0 = PC).
- REG_W, 16, width of each debug register.
- DEPTH, 16, buffer entries; power of two, ≥2.
- SEQ_W, 16, width of the retirement sequence counter stored per entry.
- DROP_W, 8, width of the saturating dropped-entry counter.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- dbg_regs  in  NREGS*REG_W  flat register bus; register i at bits [i*REG_W +: REG_W].
- dbg_instruction_retired  in  1  retirement strobe; a capture event is its rising edge.
- dbg_halted  in  1  CPU halted flag, sampled together with the capture event.
- arm  in  1  one-cycle pulse: clear buffer and counters, enter CAPTURE.
- ring_mode  in  1  0 = fill-and-stop (drop new when full), 1 = ring (overwrite oldest); sampled on arm only.
- rd_valid  out  1  buffer non-empty.
- rd_ready  in  1  consumer accepts head entry when rd_valid & rd_ready.
- rd_data  out  SEQ_W+1+NREGS*REG_W  head entry {seq, halted, regs}.
- count  out  $clog2(DEPTH)+1  entries held.
- dropped  out  DROP_W  entries lost, saturating at all-ones.
- state  out  2  0 = IDLE, 1 = CAPTURE, 2 = FROZEN.

Behaviour:
- Reset: state = IDLE, count = 0, rd_valid = 0, dropped = 0, seq counter = 0, pointers = 0, edge-detect register = 0, latched mode = fill. rd_data is don't-care while rd_valid = 0.
- Edge detect: a registered copy of dbg_instruction_retired; event = retired & ~retired_q. A strobe held high for N cycles yields one event. The edge-detect register updates in every state.
- IDLE: events ignored. arm -> CAPTURE.
- CAPTURE: on each event:
  - Entry {seq, dbg_halted, dbg_regs} is sampled that cycle and written at the next posedge.
  - count/rd_valid reflect it the cycle after the event (1-cycle latency).
  - seq increments after every event, including dropped ones, and wraps modulo 2^SEQ_W. The first entry after arm has seq = 0.
- Halt freeze: if dbg_halted = 1 at an event, that entry is written (subject to the full rules below) and state -> FROZEN.
- FROZEN: events ignored, buffer retained and readable. arm -> CAPTURE.
- arm in any state: pointers, count, dropped and seq are cleared; ring_mode is latched; state -> CAPTURE. A read or event in the same cycle as arm is discarded.
- Read: when rd_valid & rd_ready, the head pops at posedge. rd_data is a combinational view of the head (first-word-fall-through). Reads are legal in all states.
- Full, fill mode, event: entry discarded, dropped += 1 (saturating).
- Full, ring mode, event: oldest entry overwritten, read pointer advances, dropped += 1, count stays DEPTH.
- Full, event with simultaneous pop (either mode): pop and write both occur, count unchanged, no drop.
- Empty, event with rd_ready high: no bypass; the entry becomes visible next cycle.
- Pointer wrap: pointers wrap modulo DEPTH. count is an explicit counter distinguishing full from empty.
- Reset mid-capture: all state returns to reset values in one cycle. Buffer RAM contents are not cleared but are unreachable.

Test Plan:
- Reset, arm (ring_mode = 0), then 3 retire pulses with PC = 0x0100, 0x0101, 0x0103 -> count = 3; drained entries have seq 0, 1, 2 and PC fields 0x0100, 0x0101, 0x0103; dropped = 0; state = 1.
- Fill mode, DEPTH = 16, 20 events, no reads -> count = 16, dropped = 4, entries hold seq 0–15.
- Ring mode, DEPTH = 16, 20 events -> count = 16, dropped = 4, entries hold seq 4–19 in order.
- Retire strobe held high for 5 cycles -> exactly one entry captured. 5th event with dbg_halted = 1 -> that entry has halted = 1, state = 2; further events leave count = 5.
- Buffer full in fill mode, event coincident with rd_ready = 1 -> head seq 0 popped, new entry accepted, count stays 16, dropped stays 0.
- Reset asserted after 7 captures -> next cycle count = 0, rd_valid = 0, state = 0, dropped = 0. Re-arm and first entry has seq = 0.
